// File: rtl/l2dr_req_arb.sv
// l2dr_req_arb: shares the L2-to-directory request channel between the L2
// cache (even node id) and the L2TLB (odd node id). Requests go through
// round-robin arbitration, and each requester has a limit on outstanding
// requests. Directory snacks are steered back by node-id parity.
module l2dr_req_arb #(
  parameter int REQ_W         = 64,
  parameter int SNACK_W       = 64,
  parameter int REQ_NID_LSB   = 0,
  parameter int SNACK_NID_LSB = 0,
  parameter int MAX_OUT       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l2_req_valid,
  output logic               l2_req_retry,
  input  logic [REQ_W-1:0]   l2_req,
  input  logic               tlb_req_valid,
  output logic               tlb_req_retry,
  input  logic [REQ_W-1:0]   tlb_req,
  output logic               l2todr_req_valid,
  input  logic               l2todr_req_retry,
  output logic [REQ_W-1:0]   l2todr_req,
  input  logic               drtol2_snack_valid,
  output logic               drtol2_snack_retry,
  input  logic [SNACK_W-1:0] drtol2_snack,
  output logic               l2_snack_valid,
  input  logic               l2_snack_retry,
  output logic [SNACK_W-1:0] l2_snack,
  output logic               tlb_snack_valid,
  input  logic               tlb_snack_retry,
  output logic [SNACK_W-1:0] tlb_snack,
  output logic               err_underflow
);

  localparam logic [3:0] LP_MAX_OUT = 4'(MAX_OUT);

  // rr encoding: 0 favours L2, 1 favours L2TLB
  logic               r_rr;
  logic [3:0]         r_l2_out;
  logic [3:0]         r_tlb_out;
  logic               r_req_valid;
  logic [REQ_W-1:0]   r_req;
  logic               r_snk_valid;
  logic               r_snk_dst;
  logic [SNACK_W-1:0] r_snk;
  logic               r_err;

  logic               w_req_load;
  logic               w_l2_elig;
  logic               w_tlb_elig;
  logic               w_gnt_l2;
  logic               w_gnt_tlb;
  logic               w_l2_xfer;
  logic               w_tlb_xfer;
  logic [REQ_W-1:0]   w_req_next;
  logic               w_snk_drain;
  logic               w_snk_in;
  logic               w_l2_dec;
  logic               w_tlb_dec;
  logic               w_underflow;

  // Arbitration, retries and the tagged payload for the output register
  always_comb begin
    w_req_load  = ~r_req_valid | ~l2todr_req_retry;
    // Eligibility uses registered counts, so a same-cycle snack does not unblock
    w_l2_elig   = l2_req_valid  & (r_l2_out  < LP_MAX_OUT);
    w_tlb_elig  = tlb_req_valid & (r_tlb_out < LP_MAX_OUT);
    w_gnt_l2    = w_l2_elig  & (~w_tlb_elig | ~r_rr);
    w_gnt_tlb   = w_tlb_elig & (~w_l2_elig  |  r_rr);
    w_l2_xfer   = w_gnt_l2  & w_req_load;
    w_tlb_xfer  = w_gnt_tlb & w_req_load;
    // Retries read 0 while reset is held
    l2_req_retry  = reset & ~w_l2_xfer;
    tlb_req_retry = reset & ~w_tlb_xfer;
    w_req_next  = w_gnt_tlb ? tlb_req : l2_req;
    w_req_next[REQ_NID_LSB] = w_gnt_tlb;
  end

  // Snack buffer handshake and counter decrement/underflow decisions
  always_comb begin
    w_snk_drain = r_snk_valid & (r_snk_dst ? ~tlb_snack_retry : ~l2_snack_retry);
    drtol2_snack_retry = r_snk_valid & ~w_snk_drain;
    w_snk_in    = drtol2_snack_valid & ~drtol2_snack_retry;
    w_l2_dec    = w_snk_drain & ~r_snk_dst & (r_l2_out  != 4'd0);
    w_tlb_dec   = w_snk_drain &  r_snk_dst & (r_tlb_out != 4'd0);
    w_underflow = w_snk_drain & (r_snk_dst ? (r_tlb_out == 4'd0) : (r_l2_out == 4'd0));
  end

  // Request output register and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_valid <= 1'b0;
      r_req       <= '0;
      r_rr        <= 1'b0;
    end else begin
      if (w_l2_xfer || w_tlb_xfer) begin
        r_req_valid <= 1'b1;
        r_req       <= w_req_next;
        r_rr        <= w_l2_xfer;
      end else if (w_req_load) begin
        r_req_valid <= 1'b0;
      end
    end
  end

  // Snack buffer; destination is latched from the node-id parity bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snk_valid <= 1'b0;
      r_snk_dst   <= 1'b0;
      r_snk       <= '0;
    end else begin
      if (w_snk_in) begin
        r_snk_valid <= 1'b1;
        r_snk_dst   <= drtol2_snack[SNACK_NID_LSB];
        r_snk       <= drtol2_snack;
      end else if (w_snk_drain) begin
        r_snk_valid <= 1'b0;
      end
    end
  end

  // Outstanding counters; a simultaneous increment and decrement cancel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_l2_out  <= 4'd0;
      r_tlb_out <= 4'd0;
    end else begin
      case ({w_l2_xfer, w_l2_dec})
        2'b10:   r_l2_out <= r_l2_out + 4'd1;
        2'b01:   r_l2_out <= r_l2_out - 4'd1;
        default: r_l2_out <= r_l2_out;
      endcase
      case ({w_tlb_xfer, w_tlb_dec})
        2'b10:   r_tlb_out <= r_tlb_out + 4'd1;
        2'b01:   r_tlb_out <= r_tlb_out - 4'd1;
        default: r_tlb_out <= r_tlb_out;
      endcase
    end
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else if (w_underflow) r_err <= 1'b1;
  end

  assign l2todr_req_valid = r_req_valid;
  assign l2todr_req       = r_req;
  assign l2_snack_valid   = r_snk_valid & ~r_snk_dst;
  assign tlb_snack_valid  = r_snk_valid &  r_snk_dst;
  assign l2_snack         = r_snk;
  assign tlb_snack        = r_snk;
  assign err_underflow    = r_err;

endmodule

// File: tb/tb_l2dr_req_arb.sv
// Directed bench for l2dr_req_arb: each task drives one scenario and checks inline.
module tb_l2dr_req_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic        l2_req_valid, l2_req_retry;
  logic [63:0] l2_req;
  logic        tlb_req_valid, tlb_req_retry;
  logic [63:0] tlb_req;
  logic        l2todr_req_valid, l2todr_req_retry;
  logic [63:0] l2todr_req;
  logic        drtol2_snack_valid, drtol2_snack_retry;
  logic [63:0] drtol2_snack;
  logic        l2_snack_valid, l2_snack_retry;
  logic [63:0] l2_snack;
  logic        tlb_snack_valid, tlb_snack_retry;
  logic [63:0] tlb_snack;
  logic        err_underflow;

  int n_vec = 0;
  int n_err = 0;

  l2dr_req_arb #(.REQ_W(64), .SNACK_W(64), .REQ_NID_LSB(0), .SNACK_NID_LSB(0), .MAX_OUT(4)) dut (
    .clk(clk), .reset(reset),
    .l2_req_valid(l2_req_valid), .l2_req_retry(l2_req_retry), .l2_req(l2_req),
    .tlb_req_valid(tlb_req_valid), .tlb_req_retry(tlb_req_retry), .tlb_req(tlb_req),
    .l2todr_req_valid(l2todr_req_valid), .l2todr_req_retry(l2todr_req_retry), .l2todr_req(l2todr_req),
    .drtol2_snack_valid(drtol2_snack_valid), .drtol2_snack_retry(drtol2_snack_retry), .drtol2_snack(drtol2_snack),
    .l2_snack_valid(l2_snack_valid), .l2_snack_retry(l2_snack_retry), .l2_snack(l2_snack),
    .tlb_snack_valid(tlb_snack_valid), .tlb_snack_retry(tlb_snack_retry), .tlb_snack(tlb_snack),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    l2_req_valid = 0; l2_req = '0; tlb_req_valid = 0; tlb_req = '0;
    l2todr_req_retry = 0; drtol2_snack_valid = 0; drtol2_snack = '0;
    l2_snack_retry = 0; tlb_snack_retry = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 0;
    tick(); tick();
    reset = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #2;
    n_vec++; if (l2todr_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got=%b exp=0", l2todr_req_valid); end
    n_vec++; if (l2_snack_valid !== 1'b0) begin n_err++; $display("FAIL rst_l2_snack_valid got=%b exp=0", l2_snack_valid); end
    n_vec++; if (tlb_snack_valid !== 1'b0) begin n_err++; $display("FAIL rst_tlb_snack_valid got=%b exp=0", tlb_snack_valid); end
    n_vec++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", err_underflow); end
    n_vec++; if (l2todr_req !== 64'h0) begin n_err++; $display("FAIL rst_req_payload got=%h exp=0", l2todr_req); end
    n_vec++; if (l2_snack !== 64'h0) begin n_err++; $display("FAIL rst_snack_payload got=%h exp=0", l2_snack); end
    n_vec++; if ({l2_req_retry, tlb_req_retry, drtol2_snack_retry} !== 3'b000) begin n_err++; $display("FAIL rst_retries got=%b exp=000", {l2_req_retry, tlb_req_retry, drtol2_snack_retry}); end
    tick();
    reset = 1;
    tick();
  endtask

  task automatic test_single_l2();
    reset_dut();
    l2_req_valid = 1; l2_req = 64'h0000_0000_0000_00FF;
    #1;
    n_vec++; if (l2_req_retry !== 1'b0) begin n_err++; $display("FAIL single_retry got=%b exp=0", l2_req_retry); end
    tick();
    l2_req_valid = 0;
    n_vec++; if (l2todr_req_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", l2todr_req_valid); end
    n_vec++; if (l2todr_req !== 64'h0000_0000_0000_00FE) begin n_err++; $display("FAIL single_payload got=%h exp=fe", l2todr_req); end
    n_vec++; if (dut.r_l2_out !== 4'd1) begin n_err++; $display("FAIL single_l2_out got=%0d exp=1", dut.r_l2_out); end
    tick();
    n_vec++; if (l2todr_req_valid !== 1'b0) begin n_err++; $display("FAIL single_drained got=%b exp=0", l2todr_req_valid); end
    drtol2_snack_valid = 1; drtol2_snack = 64'h10;
    tick();
    drtol2_snack_valid = 0;
    n_vec++; if ({l2_snack_valid, tlb_snack_valid} !== 2'b10) begin n_err++; $display("FAIL single_snack_dst got=%b exp=10", {l2_snack_valid, tlb_snack_valid}); end
    n_vec++; if (l2_snack !== 64'h10) begin n_err++; $display("FAIL single_snack_payload got=%h exp=10", l2_snack); end
    tick();
    n_vec++; if (dut.r_l2_out !== 4'd0) begin n_err++; $display("FAIL single_l2_out_back got=%0d exp=0", dut.r_l2_out); end
  endtask

  task automatic test_alternate();
    reset_dut();
    l2_req_valid = 1; l2_req = 64'hA1;
    tlb_req_valid = 1; tlb_req = 64'hB0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++; if (l2_req_retry !== (i % 2 == 1)) begin n_err++; $display("FAIL alt_l2_retry[%0d] got=%b exp=%b", i, l2_req_retry, (i % 2 == 1)); end
      n_vec++; if (tlb_req_retry !== (i % 2 == 0)) begin n_err++; $display("FAIL alt_tlb_retry[%0d] got=%b exp=%b", i, tlb_req_retry, (i % 2 == 0)); end
      tick();
      n_vec++; if (l2todr_req !== ((i % 2 == 0) ? 64'hA0 : 64'hB1)) begin n_err++; $display("FAIL alt_payload[%0d] got=%h exp=%h", i, l2todr_req, ((i % 2 == 0) ? 64'hA0 : 64'hB1)); end
    end
    l2_req_valid = 0; tlb_req_valid = 0;
    n_vec++; if ({dut.r_l2_out, dut.r_tlb_out} !== 8'h44) begin n_err++; $display("FAIL alt_counts got=%h exp=44", {dut.r_l2_out, dut.r_tlb_out}); end
  endtask

  task automatic test_dir_stall();
    reset_dut();
    l2_req_valid = 1; l2_req = 64'h55;
    tick();
    l2_req = 64'h66; tlb_req_valid = 1; tlb_req = 64'h77;
    l2todr_req_retry = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if ({l2_req_retry, tlb_req_retry} !== 2'b11) begin n_err++; $display("FAIL stall_retries[%0d] got=%b exp=11", i, {l2_req_retry, tlb_req_retry}); end
      n_vec++; if (l2todr_req !== 64'h54 || l2todr_req_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/54", i, l2todr_req_valid, l2todr_req); end
      tick();
    end
    l2todr_req_retry = 0;
    #1;
    n_vec++; if ({l2_req_retry, tlb_req_retry} !== 2'b10) begin n_err++; $display("FAIL stall_release got=%b exp=10", {l2_req_retry, tlb_req_retry}); end
    tick();
    tlb_req_valid = 0; l2_req_valid = 0;
    n_vec++; if (l2todr_req !== 64'h77) begin n_err++; $display("FAIL stall_next_payload got=%h exp=77", l2todr_req); end
  endtask

  task automatic test_max_out();
    reset_dut();
    l2_req_valid = 1; l2_req = 64'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (l2_req_retry !== 1'b0) begin n_err++; $display("FAIL max_fill[%0d] got=%b exp=0", i, l2_req_retry); end
      tick();
    end
    tlb_req_valid = 1; tlb_req = 64'h31;
    for (int j = 0; j < 2; j++) begin
      #1;
      n_vec++; if ({l2_req_retry, tlb_req_retry} !== 2'b10) begin n_err++; $display("FAIL max_block[%0d] got=%b exp=10", j, {l2_req_retry, tlb_req_retry}); end
      tick();
    end
    drtol2_snack_valid = 1; drtol2_snack = 64'h40;
    #1;
    n_vec++; if ({l2_req_retry, tlb_req_retry, drtol2_snack_retry} !== 3'b100) begin n_err++; $display("FAIL max_snack_in got=%b exp=100", {l2_req_retry, tlb_req_retry, drtol2_snack_retry}); end
    tick();
    drtol2_snack_valid = 0;
    #1;
    n_vec++; if (l2_snack_valid !== 1'b1) begin n_err++; $display("FAIL max_snack_out got=%b exp=1", l2_snack_valid); end
    n_vec++; if ({l2_req_retry, tlb_req_retry} !== 2'b10) begin n_err++; $display("FAIL max_same_cycle got=%b exp=10", {l2_req_retry, tlb_req_retry}); end
    tick();
    #1;
    n_vec++; if ({l2_req_retry, tlb_req_retry} !== 2'b01) begin n_err++; $display("FAIL max_regrant got=%b exp=01", {l2_req_retry, tlb_req_retry}); end
    tick();
    l2_req_valid = 0; tlb_req_valid = 0;
    n_vec++; if (l2todr_req !== 64'h20) begin n_err++; $display("FAIL max_regrant_payload got=%h exp=20", l2todr_req); end
  endtask

  task automatic test_snack_order();
    reset_dut();
    tlb_req_valid = 1; tlb_req = 64'h1;
    tick(); tick();
    tlb_req_valid = 0; l2_req_valid = 1; l2_req = 64'h2;
    tick();
    l2_req_valid = 0;
    n_vec++; if ({dut.r_l2_out, dut.r_tlb_out} !== 8'h12) begin n_err++; $display("FAIL order_setup got=%h exp=12", {dut.r_l2_out, dut.r_tlb_out}); end
    drtol2_snack_valid = 1; drtol2_snack = 64'h101;
    tick();
    tlb_snack_retry = 1;
    drtol2_snack = 64'h200;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (drtol2_snack_retry !== 1'b1) begin n_err++; $display("FAIL order_stall_retry[%0d] got=%b exp=1", i, drtol2_snack_retry); end
      n_vec++; if ({l2_snack_valid, tlb_snack_valid} !== 2'b01 || tlb_snack !== 64'h101) begin n_err++; $display("FAIL order_stall_hold[%0d] got=%b/%h exp=01/101", i, {l2_snack_valid, tlb_snack_valid}, tlb_snack); end
      n_vec++; if (dut.r_tlb_out !== 4'd2) begin n_err++; $display("FAIL order_stall_cnt[%0d] got=%0d exp=2", i, dut.r_tlb_out); end
      tick();
    end
    tlb_snack_retry = 0;
    #1;
    n_vec++; if (drtol2_snack_retry !== 1'b0) begin n_err++; $display("FAIL order_release got=%b exp=0", drtol2_snack_retry); end
    tick();
    drtol2_snack = 64'h301;
    n_vec++; if ({l2_snack_valid, tlb_snack_valid} !== 2'b10 || l2_snack !== 64'h200) begin n_err++; $display("FAIL order_second got=%b/%h exp=10/200", {l2_snack_valid, tlb_snack_valid}, l2_snack); end
    n_vec++; if (dut.r_tlb_out !== 4'd1) begin n_err++; $display("FAIL order_tlb_dec got=%0d exp=1", dut.r_tlb_out); end
    tick();
    drtol2_snack_valid = 0;
    n_vec++; if ({l2_snack_valid, tlb_snack_valid} !== 2'b01 || tlb_snack !== 64'h301 || l2_snack !== 64'h301) begin n_err++; $display("FAIL order_third got=%b/%h exp=01/301", {l2_snack_valid, tlb_snack_valid}, tlb_snack); end
    tick();
    n_vec++; if ({dut.r_l2_out, dut.r_tlb_out, l2_snack_valid, tlb_snack_valid, err_underflow} !== 11'b0) begin n_err++; $display("FAIL order_final got=%b exp=0", {dut.r_l2_out, dut.r_tlb_out, l2_snack_valid, tlb_snack_valid, err_underflow}); end
  endtask

  task automatic test_underflow();
    reset_dut();
    drtol2_snack_valid = 1; drtol2_snack = 64'h9;
    tick();
    drtol2_snack_valid = 0;
    n_vec++; if (tlb_snack_valid !== 1'b1) begin n_err++; $display("FAIL uf_delivered got=%b exp=1", tlb_snack_valid); end
    tick();
    n_vec++; if (err_underflow !== 1'b1) begin n_err++; $display("FAIL uf_flag got=%b exp=1", err_underflow); end
    n_vec++; if (dut.r_tlb_out !== 4'd0) begin n_err++; $display("FAIL uf_count got=%0d exp=0", dut.r_tlb_out); end
    tick(); tick();
    n_vec++; if (err_underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky got=%b exp=1", err_underflow); end
    reset = 0;
    #1;
    n_vec++; if ({err_underflow, l2todr_req_valid, l2_snack_valid, tlb_snack_valid} !== 4'b0) begin n_err++; $display("FAIL uf_reset got=%b exp=0000", {err_underflow, l2todr_req_valid, l2_snack_valid, tlb_snack_valid}); end
    tick();
    reset = 1;
    tick();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_single_l2();
    test_alternate();
    test_dir_stall();
    test_max_out();
    test_snack_order();
    test_underflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/l2dr_req_arb.md
# l2dr_req_arb

Arbiter and response router sharing one L2-to-directory request/snack channel between the L2 cache (even node id) and the L2TLB (odd node id). Two single-beat requesters compete for `l2todr_req` under round-robin arbitration, with a per-requester outstanding-request limit. Returning `drtol2_snack` messages are steered to the owner by node-id parity. Sits inside the l2cache, between the L2/L2TLB pipelines and the directory port.

## Interface
- `REQ_W`, 64: request payload width (`$bits(I_l2todr_req_type)`).
- `SNACK_W`, 64: snack payload width (`$bits(I_drtol2_snack_type)`).
- `REQ_NID_LSB`, 0: bit index of node-id LSB inside the request payload.
- `SNACK_NID_LSB`, 0: bit index of node-id LSB inside the snack payload.
- `MAX_OUT`, 4: max outstanding requests per requester (1..15).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `l2_req_valid` in 1 / `l2_req_retry` out 1 / `l2_req` in REQ_W: L2 request.
- `tlb_req_valid` in 1 / `tlb_req_retry` out 1 / `tlb_req` in REQ_W: L2TLB request.
- `l2todr_req_valid` out 1 / `l2todr_req_retry` in 1 / `l2todr_req` out REQ_W: merged request to directory.
- `drtol2_snack_valid` in 1 / `drtol2_snack_retry` out 1 / `drtol2_snack` in SNACK_W: directory response.
- `l2_snack_valid` out 1 / `l2_snack_retry` in 1 / `l2_snack` out SNACK_W: response to L2.
- `tlb_snack_valid` out 1 / `tlb_snack_retry` in 1 / `tlb_snack` out SNACK_W: response to L2TLB.
- `err_underflow` out 1: sticky; a snack arrived for a requester with zero outstanding.

## Operation
- Handshake on every channel: transfer occurs in a cycle where valid=1 and retry=0. A producer holds valid and payload stable while retry=1.
- Request output register (1 entry). It loads when empty, or when full and draining this cycle (`l2todr_req_valid & ~l2todr_req_retry`).
- Eligibility: a requester is eligible when its valid=1 and its outstanding count < MAX_OUT.
- Grant:
  - Only one requester eligible: it wins.
  - Both eligible: the winner is the one named by the round-robin pointer `rr`.
  - The pointer flips to the other requester on every granted transfer.
  - `rr` resets to L2.
- Retry: the granted requester's retry is 0 if the output register can load this cycle. The loser, any ineligible requester, and all requesters when the register cannot load see retry=1.
- On load, the arbiter overwrites payload bit REQ_NID_LSB with 0 for L2 and 1 for L2TLB. All other bits pass unchanged.
- Outstanding counters (`l2_out`, `tlb_out`, width 4):
  - Increment on request input transfer.
  - Decrement on snack output transfer to that requester.
  - Increment and decrement in the same cycle leave the count unchanged.
- Every request receives exactly one snack.
- Snack buffer (1 entry):
  - `drtol2_snack_retry` = buffer full and not draining this cycle.
  - The destination is latched from `drtol2_snack[SNACK_NID_LSB]`: 0 goes to L2, 1 goes to L2TLB.
  - Only the destination's valid is asserted, with the payload driven on both outputs.
  - The non-destination retry is ignored.
- Underflow: a snack whose destination counter is 0 still delivers, the counter stays at 0, and `err_underflow` sets. It clears only on reset.

## Timing
- Reset (asynchronous, `reset`=0): `l2todr_req_valid`, `l2_snack_valid`, `tlb_snack_valid` and `err_underflow` are 0. Counters are 0, `rr` is L2, buffers are empty.
- `l2todr_req` and the snack payload outputs reset to 0.
- Input retries reset to 0, and `drtol2_snack_retry` resets to 0.
- Request latency: an input transfer in cycle N gives `l2todr_req_valid`=1 in cycle N+1. Back-to-back throughput is 1 per cycle while the directory does not retry.
- Snack latency: an input transfer in cycle N gives the destination valid in cycle N+1. Throughput is 1 per cycle.
- Input retries are combinational from the current valids, counters, `rr`, buffer state and downstream retry. There is no combinational path from request valid to `l2todr_req_valid`.
- Reset asserted mid-transfer discards buffered request and snack contents and all counts immediately.
- An ineligible requester at MAX_OUT becomes eligible in the cycle after its snack transfer. A same-cycle decrement does not unblock it.

## Test plan
- Single L2 request, payload 0x...FF (nid LSB=1), no retry → `l2todr_req_valid` at N+1; payload LSB forced to 0; `l2_out`=1.
- Both requesters valid continuously for 8 cycles, directory never retries → grants alternate L2, TLB, L2, TLB…; 4 each; each loser sees retry=1 in its losing cycle.
- Directory holds `l2todr_req_retry`=1 for 5 cycles with the register full → output payload stable; both input retries=1; on release, next transfer in the same cycle.
- L2 issues 4 requests with no snacks (MAX_OUT=4) → 5th held with retry=1 while the TLB still wins every cycle; a snack with nid LSB=0 delivered → L2 regrants the following cycle.
- Snacks with nid LSB 1,0,1 back-to-back, `tlb_snack_retry`=1 for 2 cycles → `drtol2_snack_retry`=1 while stalled; order preserved; `tlb_out` decremented only on transfer.
- Snack to L2TLB with `tlb_out`=0 → delivered; `err_underflow`=1 until `reset`=0, then 0 with all valids 0.
